// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed 3-digit BCD 7-segment scanner
module bcd_display_scanner #(
  parameter int unsigned REFRESH_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES     = 16,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [2:0]  digit_en,
  output logic        invalid,
  output logic        frame_done
);

  localparam int unsigned   PW        = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] TC_VAL    = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_VAL = PW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [2:0]    DIG_OFF   = DIGIT_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [PW-1:0] prescaler;
  logic [1:0]    index;
  logic [11:0]   pending;
  logic [11:0]   display;

  logic          tc;
  logic          wrap;
  logic [3:0]    nib;
  logic          lz_blank;
  logic          in_blank;
  logic [6:0]    seg_next;
  logic [2:0]    den_next;
  logic [11:0]   display_next;
  logic          invalid_next;

  function automatic logic [6:0] seg_pattern(input logic [3:0] n);
    case (n)
      4'd0:    seg_pattern = 7'h3f;
      4'd1:    seg_pattern = 7'h06;
      4'd2:    seg_pattern = 7'h5b;
      4'd3:    seg_pattern = 7'h4f;
      4'd4:    seg_pattern = 7'h66;
      4'd5:    seg_pattern = 7'h6d;
      4'd6:    seg_pattern = 7'h7d;
      4'd7:    seg_pattern = 7'h07;
      4'd8:    seg_pattern = 7'h7f;
      4'd9:    seg_pattern = 7'h6f;
      default: seg_pattern = 7'h40;
    endcase
  endfunction

  always_comb begin
    tc   = (prescaler == TC_VAL);
    wrap = tc && (index == 2'd2);

    case (index)
      2'd0:    nib = display[3:0];
      2'd1:    nib = display[7:4];
      default: nib = display[11:8];
    endcase

    // Invalid nibbles are non-zero, so they are never treated as leading zeros.
    lz_blank = blank_lz &&
               (((index == 2'd2) && (display[11:8] == 4'd0)) ||
                ((index == 2'd1) && (display[11:8] == 4'd0) && (display[7:4] == 4'd0)));

    in_blank = (prescaler < BLANK_VAL);
    seg_next = (in_blank || lz_blank) ? 7'h00 : seg_pattern(nib);
    den_next = in_blank ? 3'b000 : (3'b001 << index);

    display_next = load ? bcd_in : pending;
    invalid_next = (display_next[3:0] > 4'd9) || (display_next[7:4] > 4'd9) ||
                   (display_next[11:8] > 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      index      <= 2'd0;
      pending    <= 12'h000;
      display    <= 12'h000;
      seg        <= SEG_OFF;
      digit_en   <= DIG_OFF;
      invalid    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      prescaler <= tc ? '0 : prescaler + 1'b1;
      if (tc) begin
        index <= (index == 2'd2) ? 2'd0 : index + 2'd1;
      end
      if (load) begin
        pending <= bcd_in;
      end
      // Display only changes at the frame wrap so a frame never mixes two values.
      if (wrap) begin
        display <= display_next;
        invalid <= invalid_next;
      end
      frame_done <= wrap;
      seg        <= SEG_ACTIVE_LOW ? ~seg_next : seg_next;
      digit_en   <= DIGIT_ACTIVE_LOW ? ~den_next : den_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - directed self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

  logic        clk;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [2:0]  digit_en;
  logic        invalid;
  logic        frame_done;

  int n_tests;
  int n_fail;

  logic [6:0] seg_cap[12];
  logic [2:0] den_cap[12];
  logic       fd_cap[12];
  logic [6:0] exp3[3];
  logic [6:0] exp_seg;
  logic [2:0] exp_den;
  logic       ok;
  int         cnt;

  bcd_display_scanner #(
    .REFRESH_DIV(4),
    .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1'b0),
    .DIGIT_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bcd_in(bcd_in),
    .load(load),
    .blank_lz(blank_lz),
    .seg(seg),
    .digit_en(digit_en),
    .invalid(invalid),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [11:0] v);
    @(negedge clk);
    bcd_in = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_fd(output logic found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Samples one full frame starting from the negedge where frame_done was seen.
  task automatic capture_frame();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seg_cap[i] = seg;
      den_cap[i] = digit_en;
      fd_cap[i]  = frame_done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bcd_in = 12'h000; load = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (seg !== 7'h00 || digit_en !== 3'b000 || invalid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: seg=%h den=%b inv=%b fd=%b, want 00 000 0 0",
               seg, digit_en, invalid, frame_done);
    end
    #1 rst_n = 1'b1;
    capture_frame();
    exp3[0] = 7'h3f; exp3[1] = 7'h3f; exp3[2] = 7'h3f;
    for (int i = 0; i < 12; i++) begin
      exp_den = (i % 4 == 0) ? 3'b000 : 3'(1 << (i / 4));
      exp_seg = (i % 4 == 0) ? 7'h00 : exp3[i / 4];
      n_tests++;
      if (den_cap[i] !== exp_den || seg_cap[i] !== exp_seg) begin
        n_fail++;
        $display("FAIL first_frame[%0d]: den=%b seg=%h, want %b %h", i, den_cap[i], seg_cap[i], exp_den, exp_seg);
      end
    end
    n_tests++;
    if (fd_cap[11] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_frame_done: got %b want 1", fd_cap[11]);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_load(12'h2a9);
    wait_fd(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL mid_reset_wrap_timeout: got 0 want 1"); end
    repeat (6) @(negedge clk);
    n_tests++;
    if (digit_en !== 3'b010 || seg !== 7'h40 || invalid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: den=%b seg=%h inv=%b, want 010 40 1", digit_en, seg, invalid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (seg !== 7'h00 || digit_en !== 3'b000 || invalid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: seg=%h den=%b inv=%b fd=%b, want 00 000 0 0",
               seg, digit_en, invalid, frame_done);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    capture_frame();
    exp3[0] = 7'h3f; exp3[1] = 7'h3f; exp3[2] = 7'h3f;
    for (int i = 0; i < 12; i++) begin
      exp_den = (i % 4 == 0) ? 3'b000 : 3'(1 << (i / 4));
      exp_seg = (i % 4 == 0) ? 7'h00 : exp3[i / 4];
      n_tests++;
      if (den_cap[i] !== exp_den || seg_cap[i] !== exp_seg) begin
        n_fail++;
        $display("FAIL restart_frame[%0d]: den=%b seg=%h, want %b %h", i, den_cap[i], seg_cap[i], exp_den, exp_seg);
      end
    end
  endtask

  task automatic test_scan_280();
    do_load(12'h280);
    wait_fd(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL scan_wrap_timeout: got 0 want 1"); end
    capture_frame();
    exp3[0] = 7'h3f; exp3[1] = 7'h7f; exp3[2] = 7'h5b;
    for (int i = 0; i < 12; i++) begin
      exp_den = (i % 4 == 0) ? 3'b000 : 3'(1 << (i / 4));
      exp_seg = (i % 4 == 0) ? 7'h00 : exp3[i / 4];
      n_tests++;
      if (den_cap[i] !== exp_den || seg_cap[i] !== exp_seg) begin
        n_fail++;
        $display("FAIL scan_280[%0d]: den=%b seg=%h, want %b %h", i, den_cap[i], seg_cap[i], exp_den, exp_seg);
      end
    end
  endtask

  task automatic test_blank_lz();
    blank_lz = 1'b1;
    do_load(12'h007);
    wait_fd(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL lz_wrap_timeout: got 0 want 1"); end
    capture_frame();
    exp3[0] = 7'h07; exp3[1] = 7'h00; exp3[2] = 7'h00;
    for (int i = 0; i < 12; i++) begin
      exp_den = (i % 4 == 0) ? 3'b000 : 3'(1 << (i / 4));
      exp_seg = (i % 4 == 0) ? 7'h00 : exp3[i / 4];
      n_tests++;
      if (den_cap[i] !== exp_den || seg_cap[i] !== exp_seg) begin
        n_fail++;
        $display("FAIL lz_on[%0d]: den=%b seg=%h, want %b %h", i, den_cap[i], seg_cap[i], exp_den, exp_seg);
      end
    end
    blank_lz = 1'b0;
    capture_frame();
    exp3[0] = 7'h07; exp3[1] = 7'h3f; exp3[2] = 7'h3f;
    for (int i = 0; i < 12; i++) begin
      exp_den = (i % 4 == 0) ? 3'b000 : 3'(1 << (i / 4));
      exp_seg = (i % 4 == 0) ? 7'h00 : exp3[i / 4];
      n_tests++;
      if (den_cap[i] !== exp_den || seg_cap[i] !== exp_seg) begin
        n_fail++;
        $display("FAIL lz_off[%0d]: den=%b seg=%h, want %b %h", i, den_cap[i], seg_cap[i], exp_den, exp_seg);
      end
    end
  endtask

  task automatic test_invalid();
    do_load(12'h2a9);
    wait_fd(ok);
    n_tests++;
    if (!ok || invalid !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_set: found=%b inv=%b, want 1 1", ok, invalid);
    end
    capture_frame();
    exp3[0] = 7'h6f; exp3[1] = 7'h40; exp3[2] = 7'h5b;
    for (int i = 0; i < 12; i++) begin
      exp_den = (i % 4 == 0) ? 3'b000 : 3'(1 << (i / 4));
      exp_seg = (i % 4 == 0) ? 7'h00 : exp3[i / 4];
      n_tests++;
      if (den_cap[i] !== exp_den || seg_cap[i] !== exp_seg) begin
        n_fail++;
        $display("FAIL invalid_2a9[%0d]: den=%b seg=%h, want %b %h", i, den_cap[i], seg_cap[i], exp_den, exp_seg);
      end
    end
    do_load(12'h300);
    n_tests++;
    if (invalid !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_sticky: got %b want 1", invalid);
    end
    wait_fd(ok);
    n_tests++;
    if (!ok || invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_clear: found=%b inv=%b, want 1 0", ok, invalid);
    end
    capture_frame();
    exp3[0] = 7'h3f; exp3[1] = 7'h3f; exp3[2] = 7'h4f;
    for (int i = 0; i < 12; i++) begin
      exp_den = (i % 4 == 0) ? 3'b000 : 3'(1 << (i / 4));
      exp_seg = (i % 4 == 0) ? 7'h00 : exp3[i / 4];
      n_tests++;
      if (den_cap[i] !== exp_den || seg_cap[i] !== exp_seg) begin
        n_fail++;
        $display("FAIL valid_300[%0d]: den=%b seg=%h, want %b %h", i, den_cap[i], seg_cap[i], exp_den, exp_seg);
      end
    end
  endtask

  task automatic test_load_on_wrap();
    wait_fd(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL wrap_load_timeout: got 0 want 1"); end
    repeat (10) @(negedge clk);
    bcd_in = 12'h299; load = 1'b1;
    @(negedge clk);
    bcd_in = 12'h967;
    @(negedge clk);
    load = 1'b0;
    n_tests++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_load_fd: got %b want 1", frame_done);
    end
    capture_frame();
    exp3[0] = 7'h07; exp3[1] = 7'h7d; exp3[2] = 7'h6f;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      exp_den = (i % 4 == 0) ? 3'b000 : 3'(1 << (i / 4));
      exp_seg = (i % 4 == 0) ? 7'h00 : exp3[i / 4];
      if (fd_cap[i] === 1'b1) cnt++;
      n_tests++;
      if (den_cap[i] !== exp_den || seg_cap[i] !== exp_seg) begin
        n_fail++;
        $display("FAIL wrap_load_967[%0d]: den=%b seg=%h, want %b %h", i, den_cap[i], seg_cap[i], exp_den, exp_seg);
      end
    end
    n_tests++;
    if (cnt != 1 || fd_cap[11] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_load_pulses: count=%0d last=%b, want 1 1", cnt, fd_cap[11]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bcd_in = 12'h111; load = 1'b1;
    @(negedge clk);
    bcd_in = 12'h456;
    @(negedge clk);
    load = 1'b0;
    wait_fd(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_wrap_timeout: got 0 want 1"); end
    capture_frame();
    exp3[0] = 7'h7d; exp3[1] = 7'h6d; exp3[2] = 7'h66;
    for (int i = 0; i < 12; i++) begin
      exp_den = (i % 4 == 0) ? 3'b000 : 3'(1 << (i / 4));
      exp_seg = (i % 4 == 0) ? 7'h00 : exp3[i / 4];
      n_tests++;
      if (den_cap[i] !== exp_den || seg_cap[i] !== exp_seg) begin
        n_fail++;
        $display("FAIL b2b_456[%0d]: den=%b seg=%h, want %b %h", i, den_cap[i], seg_cap[i], exp_den, exp_seg);
      end
    end
  endtask

  task automatic test_frame_period();
    wait_fd(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL period_wrap_timeout: got 0 want 1"); end
    for (int f = 0; f < 3; f++) begin
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        cnt++;
        if (frame_done === 1'b1) break;
      end
      n_tests++;
      if (cnt != 12) begin
        n_fail++;
        $display("FAIL frame_period[%0d]: got %0d cycles want 12", f, cnt);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_reset_mid_scan();
    test_scan_280();
    test_blank_lz();
    test_invalid();
    test_load_on_wrap();
    test_back_to_back();
    test_frame_period();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
